// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbar_pkg
// Description : Shared crossbar types: AXI burst encoding, the default
//               address-channel request layout and pointer sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package xbar_pkg;

  localparam int unsigned XBAR_ID_WIDTH   = 4;
  localparam int unsigned XBAR_ADDR_WIDTH = 32;
  localparam int unsigned XBAR_LEN_WIDTH  = 4;
  localparam int unsigned XBAR_SIZE_WIDTH = 3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_t;

  // Default crossbar address request; FIFO instances keep the same field
  // order with their own widths.
  typedef struct packed {
    logic [XBAR_ID_WIDTH-1:0]   id;
    logic [XBAR_ADDR_WIDTH-1:0] addr;
    logic [XBAR_LEN_WIDTH-1:0]  len;
    logic [XBAR_SIZE_WIDTH-1:0] size;
    axi_burst_t                 burst;
  } addr_req_t;

  // Pointer width for a buffer of 'depth' entries, never less than one bit.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_ctrl
// Description : Write/read pointers and occupancy count for a DEPTH-entry
//               circular buffer. Pointers wrap explicitly at DEPTH-1, so any
//               DEPTH >= 2 is supported. Flush overrides both enables.
// Ports       : clk, rst_n (sync, active low), flush, wr_en, rd_en,
//               wr_ptr, rd_ptr, count, full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
  import xbar_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_width(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/axi_addr_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_addr_chan_fifo
// Description : AXI AW/AR pending-request buffer for the crossbar. Valid/ready
//               on both sides, any DEPTH >= 2, optional empty bypass, flush,
//               occupancy count and almost_full.
// Ports       : ACLK, ARESETn (sync, active low), flush
//               s_valid/s_ready, s_id, s_addr, s_len, s_size, s_burst
//               m_valid/m_ready, m_id, m_addr, m_len, m_size, m_burst
//               count, almost_full
// Revision    : 1.0 - initial release
// ============================================================================
module axi_addr_chan_fifo
  import xbar_pkg::*;
#(
  parameter  int unsigned DEPTH      = 4,
  parameter  int unsigned ID_WIDTH   = XBAR_ID_WIDTH,
  parameter  int unsigned ADDR_WIDTH = XBAR_ADDR_WIDTH,
  parameter  int unsigned LEN_WIDTH  = XBAR_LEN_WIDTH,
  parameter  int unsigned SIZE_WIDTH = XBAR_SIZE_WIDTH,
  parameter  int unsigned AF_THRESH  = DEPTH - 1,
  parameter  bit          BYPASS     = 1'b0,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ID_WIDTH-1:0]   s_id,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [LEN_WIDTH-1:0]  s_len,
  input  logic [SIZE_WIDTH-1:0] s_size,
  input  logic [1:0]            s_burst,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LEN_WIDTH-1:0]  m_len,
  output logic [SIZE_WIDTH-1:0] m_size,
  output logic [1:0]            m_burst,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  // Same field order as addr_req_t, sized for this instance.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [SIZE_WIDTH-1:0] size;
    axi_burst_t            burst;
  } entry_t;

  entry_t           s_req;
  entry_t           head_req;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             pass;
  logic             wr_en;
  logic             rd_en;

  always_comb begin
    s_req       = '0;
    s_req.id    = s_id;
    s_req.addr  = s_addr;
    s_req.len   = s_len;
    s_req.size  = s_size;
    s_req.burst = axi_burst_t'(s_burst);
  end

  // Readiness depends on state only, so a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign s_ready = ARESETn & ~full;

  generate
    if (BYPASS) begin : g_bypass
      assign m_valid  = ARESETn & (~empty | s_valid);
      // Beat crosses an empty FIFO directly; storage and count untouched.
      assign pass     = ARESETn & empty & s_valid & m_ready;
      assign head_req = empty ? s_req : mem_q[rd_ptr];
    end else begin : g_no_bypass
      assign m_valid  = ARESETn & ~empty;
      assign pass     = 1'b0;
      assign head_req = mem_q[rd_ptr];
    end
  endgenerate

  assign push  = s_valid & s_ready;
  assign pop   = m_valid & m_ready;
  assign wr_en = push & ~pass;
  assign rd_en = pop & ~pass;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .flush  (flush),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Payload storage is deliberately not reset; only the pointers define
  // which entries are live.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && !flush) mem_d[wr_ptr] = s_req;
  end

  always_ff @(posedge ACLK) begin
    mem_q <= mem_d;
  end

  assign m_id        = head_req.id;
  assign m_addr      = head_req.addr;
  assign m_len       = head_req.len;
  assign m_size      = head_req.size;
  assign m_burst     = head_req.burst;
  assign almost_full = ARESETn & (count >= CNT_W'(AF_THRESH));

endmodule
`default_nettype wire

// File: tb/tb_axi_addr_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_addr_chan_fifo
// Description : Self-checking bench for axi_addr_chan_fifo. Two DEPTH=5
//               instances (plain and bypass) share one stimulus stream and
//               are compared against queue-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_addr_chan_fifo;

  localparam int DEPTH = 5;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [3:0]  s_id = '0;
  logic [31:0] s_addr = '0;
  logic [3:0]  s_len = '0;
  logic [2:0]  s_size = '0;
  logic [1:0]  s_burst = '0;
  logic        m_ready = 1'b0;

  logic        a_s_ready, a_m_valid, a_af;
  logic [3:0]  a_m_id;
  logic [31:0] a_m_addr;
  logic [3:0]  a_m_len;
  logic [2:0]  a_m_size;
  logic [1:0]  a_m_burst;
  logic [2:0]  a_count;

  logic        b_s_ready, b_m_valid, b_af;
  logic [3:0]  b_m_id;
  logic [31:0] b_m_addr;
  logic [3:0]  b_m_len;
  logic [2:0]  b_m_size;
  logic [1:0]  b_m_burst;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;

  req_t qa[$];
  req_t qb[$];

  always #5 clk = ~clk;

  axi_addr_chan_fifo #(
    .DEPTH(DEPTH), .ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(4),
    .SIZE_WIDTH(3), .AF_THRESH(4), .BYPASS(1'b0)
  ) dut_a (
    .ACLK(clk), .ARESETn(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_id(s_id), .s_addr(s_addr),
    .s_len(s_len), .s_size(s_size), .s_burst(s_burst),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_id(a_m_id), .m_addr(a_m_addr),
    .m_len(a_m_len), .m_size(a_m_size), .m_burst(a_m_burst),
    .count(a_count), .almost_full(a_af)
  );

  axi_addr_chan_fifo #(
    .DEPTH(DEPTH), .ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(4),
    .SIZE_WIDTH(3), .AF_THRESH(4), .BYPASS(1'b1)
  ) dut_b (
    .ACLK(clk), .ARESETn(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_id(s_id), .s_addr(s_addr),
    .s_len(s_len), .s_size(s_size), .s_burst(s_burst),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_id(b_m_id), .m_addr(b_m_addr),
    .m_len(b_m_len), .m_size(b_m_size), .m_burst(b_m_burst),
    .count(b_count), .almost_full(b_af)
  );

  // ---------------- reference model ----------------
  function automatic req_t cur_req();
    return {s_id, s_addr, s_len, s_size, s_burst};
  endfunction

  function automatic int msize(bit byp);
    return byp ? qb.size() : qa.size();
  endfunction

  // {s_ready, m_valid, count[2:0], almost_full}
  function automatic logic [5:0] exp_status(bit byp);
    int   n  = msize(byp);
    logic sr = rst_n && (n < DEPTH);
    logic mv = rst_n && ((n > 0) || (byp && s_valid));
    logic af = rst_n && (n >= 4);
    return {sr, mv, 3'(n), af};
  endfunction

  function automatic req_t exp_head(bit byp);
    if (msize(byp) > 0) return byp ? qb[0] : qa[0];
    return cur_req();
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      bit         byp = (k == 1);
      logic [5:0] st  = exp_status(byp);
      bit         psh = s_valid && st[5];
      bit         pp  = st[4] && m_ready;
      int         n   = msize(byp);
      if (!rst_n || flush) begin
        if (byp) qb.delete(); else qa.delete();
      end else if (!(byp && n == 0 && psh && pp)) begin
        if (pp)  begin if (byp) void'(qb.pop_front()); else void'(qa.pop_front()); end
        if (psh) begin if (byp) qb.push_back(cur_req()); else qa.push_back(cur_req()); end
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [3:0] id);
    s_valid = v;
    s_id    = id;
    s_addr  = $urandom;
    s_len   = 4'($urandom);
    s_size  = 3'($urandom);
    s_burst = 2'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; drive(1'b1, 4'd0);
    tick(); tick(); settle();
    checks++;
    if ({a_s_ready, a_m_valid, a_af} !== 3'b000) begin
      errors++; $display("FAIL reset_a_outputs: got %b expected 000", {a_s_ready, a_m_valid, a_af});
    end
    checks++;
    if ({b_s_ready, b_m_valid, b_af} !== 3'b000) begin
      errors++; $display("FAIL reset_b_outputs: got %b expected 000", {b_s_ready, b_m_valid, b_af});
    end
    rst_n = 1'b1; drive(1'b0, 4'd0); settle();
    checks++;
    if ({a_count, a_s_ready, a_m_valid} !== {3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_release: got %b expected 00010", {a_count, a_s_ready, a_m_valid});
    end
    tick();
  endtask

  task automatic test_fill_drain();
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'(i)); settle();
      checks++;
      if (a_s_ready !== 1'b1) begin
        errors++; $display("FAIL fill_s_ready[%0d]: got %b expected 1", i, a_s_ready);
      end
      tick(); settle();
      checks++;
      if (a_count !== 3'(i) || b_count !== 3'(i)) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d/%0d expected %0d", i, a_count, b_count, i);
      end
      checks++;
      if (a_af !== logic'(i >= 4)) begin
        errors++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, a_af, (i >= 4));
      end
    end
    drive(1'b0, 4'd0); settle();
    checks++;
    if (a_s_ready !== 1'b0) begin
      errors++; $display("FAIL full_s_ready: got %b expected 0", a_s_ready);
    end
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      settle();
      checks++;
      if (a_m_valid !== 1'b1 || a_m_id !== 4'(i)) begin
        errors++; $display("FAIL drain_order[%0d]: got valid=%b id=%0d expected valid=1 id=%0d", i, a_m_valid, a_m_id, i);
      end
      tick();
    end
    settle();
    checks++;
    if (a_count !== 3'd0 || a_m_valid !== 1'b0) begin
      errors++; $display("FAIL drained: got count=%0d valid=%b expected 0 0", a_count, a_m_valid);
    end
  endtask

  task automatic test_wrap();
    m_ready = 1'b0;
    drive(1'b1, 4'd6); tick();
    drive(1'b1, 4'd7); tick();
    m_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [3:0] eid;
      eid = 4'(6 + k);
      drive(1'b1, 4'(8 + k)); settle();
      checks++;
      if (a_m_id !== eid || a_count !== 3'd2) begin
        errors++; $display("FAIL wrap[%0d]: got id=%0d count=%0d expected id=%0d count=2", k, a_m_id, a_count, eid);
      end
      tick();
    end
    drive(1'b0, 4'd0);
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_full_simul();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(1'b1, 4'(i + 1)); tick(); end
    m_ready = 1'b1; drive(1'b1, 4'd9); settle();
    checks++;
    if (a_s_ready !== 1'b0 || a_count !== 3'd5) begin
      errors++; $display("FAIL full_both_pre: got ready=%b count=%0d expected 0 5", a_s_ready, a_count);
    end
    tick(); settle();
    checks++;
    if (a_count !== 3'd4 || a_m_id !== 4'd2) begin
      errors++; $display("FAIL full_both_pop: got count=%0d id=%0d expected 4 2", a_count, a_m_id);
    end
    drive(1'b1, 4'd10); tick(); settle();
    checks++;
    if (a_count !== 3'd4 || a_m_id !== 4'd3) begin
      errors++; $display("FAIL full_both_steady: got count=%0d id=%0d expected 4 3", a_count, a_m_id);
    end
    drive(1'b0, 4'd0);
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_bypass();
    m_ready = 1'b1; drive(1'b1, 4'd3); s_addr = 32'h1000; settle();
    checks++;
    if (b_m_valid !== 1'b1 || b_m_addr !== 32'h1000 || b_m_id !== 4'd3) begin
      errors++; $display("FAIL bypass_pass: got valid=%b addr=%h expected 1 00001000", b_m_valid, b_m_addr);
    end
    checks++;
    if (a_m_valid !== 1'b0) begin
      errors++; $display("FAIL nobypass_valid: got %b expected 0", a_m_valid);
    end
    tick(); settle();
    checks++;
    if (b_count !== 3'd0 || a_count !== 3'd1) begin
      errors++; $display("FAIL bypass_count: got b=%0d a=%0d expected 0 1", b_count, a_count);
    end
    m_ready = 1'b0; drive(1'b1, 4'd4); s_addr = 32'h1000; tick(); settle();
    checks++;
    if (b_count !== 3'd1 || b_m_addr !== 32'h1000 || b_m_id !== 4'd4) begin
      errors++; $display("FAIL bypass_store: got count=%0d addr=%h id=%0d expected 1 00001000 4", b_count, b_m_addr, b_m_id);
    end
    drive(1'b0, 4'd0); m_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1'b1, 4'(i)); tick(); end
    flush = 1'b1; drive(1'b1, 4'd12); tick();
    flush = 1'b0; drive(1'b0, 4'd0); settle();
    checks++;
    if ({a_count, a_m_valid, a_s_ready} !== {3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL flush_a: got %b expected 00001", {a_count, a_m_valid, a_s_ready});
    end
    checks++;
    if ({b_count, b_m_valid, b_s_ready} !== {3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL flush_b: got %b expected 00001", {b_count, b_m_valid, b_s_ready});
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin drive(1'b1, 4'(i)); tick(); end
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if ({a_s_ready, a_m_valid, b_s_ready, b_m_valid} !== 4'b0000) begin
        errors++; $display("FAIL reset_mid[%0d]: got %b expected 0000", c, {a_s_ready, a_m_valid, b_s_ready, b_m_valid});
      end
      tick();
    end
    rst_n = 1'b1; drive(1'b0, 4'd0); settle();
    checks++;
    if (a_count !== 3'd0 || a_s_ready !== 1'b1 || b_count !== 3'd0) begin
      errors++; $display("FAIL reset_mid_release: got count=%0d ready=%b expected 0 1", a_count, a_s_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [5:0] ea, eb;
      req_t       ha, hb;
      drive(logic'($urandom_range(99, 0) < 60), 4'($urandom));
      m_ready = logic'($urandom_range(99, 0) < 50);
      flush   = logic'($urandom_range(99, 0) < 3);
      settle();
      ea = exp_status(1'b0);
      eb = exp_status(1'b1);
      ha = exp_head(1'b0);
      hb = exp_head(1'b1);
      checks++;
      if ({a_s_ready, a_m_valid, a_count, a_af} !== ea) begin
        errors++; $display("FAIL rand_status_a[%0d]: got %b expected %b", c, {a_s_ready, a_m_valid, a_count, a_af}, ea);
      end
      checks++;
      if ({b_s_ready, b_m_valid, b_count, b_af} !== eb) begin
        errors++; $display("FAIL rand_status_b[%0d]: got %b expected %b", c, {b_s_ready, b_m_valid, b_count, b_af}, eb);
      end
      if (ea[4]) begin
        checks++;
        if ({a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst} !== ha) begin
          errors++; $display("FAIL rand_head_a[%0d]: got %h expected %h", c, {a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst}, ha);
        end
      end
      if (eb[4]) begin
        checks++;
        if ({b_m_id, b_m_addr, b_m_len, b_m_size, b_m_burst} !== hb) begin
          errors++; $display("FAIL rand_head_b[%0d]: got %h expected %h", c, {b_m_id, b_m_addr, b_m_len, b_m_size, b_m_burst}, hb);
        end
      end
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_bypass();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
